// File: rtl/punc_control.sv
// Multi-cycle fetch/decode/execute control FSM for the PUnC LC3 core.
// Strobes are decoded combinationally from the current state and instruction.
module punc_control #(
  parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        nzp_true,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        ir_clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_r_addr_sel,
  output logic [1:0]  mem_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        rf_w_wr,
  output logic        rf_r0_addr_sel,
  output logic        rf_r0_rd,
  output logic        rf_r1_rd,
  output logic        temp_ld,
  output logic        nzp_ld,
  output logic        nzp_clr,
  output logic [1:0]  alu_sel,
  output logic        alu_first_val_sel,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;

  state_t     state;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[15:12];
  assign unused_ir = ^{ir[10:6], ir[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
        S_EXEC:   state <= (opcode == OP_LDI || opcode == OP_STI) ? S_EXEC2 : S_FETCH;
        S_EXEC2:  state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_ld             = 1'b0;
    pc_clr            = 1'b0;
    pc_inc            = 1'b0;
    pc_sel            = 2'd0;
    ir_ld             = 1'b0;
    ir_clr            = 1'b0;
    mem_rd            = 1'b0;
    mem_wr            = 1'b0;
    mem_r_addr_sel    = 2'd0;
    mem_w_addr_sel    = 2'd0;
    rf_w_data_sel     = 2'd0;
    rf_w_addr_sel     = 1'b0;
    rf_w_wr           = 1'b0;
    rf_r0_addr_sel    = 1'b0;
    rf_r0_rd          = 1'b0;
    rf_r1_rd          = 1'b0;
    temp_ld           = 1'b0;
    nzp_ld            = 1'b0;
    nzp_clr           = 1'b0;
    alu_sel           = 2'd0;
    alu_first_val_sel = 1'b0;
    halted            = 1'b0;

    // Reset masks whatever state is current, so an in-flight write is dropped
    if (rst) begin
      pc_clr  = 1'b1;
      ir_clr  = 1'b1;
      nzp_clr = 1'b1;
    end else begin
      case (state)
        S_FETCH: begin
          mem_rd = 1'b1;
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND: begin
              rf_r1_rd      = 1'b1;
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              nzp_ld        = 1'b1;
              alu_sel       = (opcode == OP_ADD) ? 2'd1 : 2'd2;
              if (ir[5]) begin
                alu_first_val_sel = 1'b1;
              end else begin
                rf_r0_addr_sel = 1'b1;
                rf_r0_rd       = 1'b1;
              end
            end
            OP_NOT: begin
              rf_r1_rd      = 1'b1;
              alu_sel       = 2'd3;
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              nzp_ld        = 1'b1;
            end
            OP_BR: begin
              pc_ld = nzp_true;
            end
            OP_JMP: begin
              rf_r1_rd = 1'b1;
              pc_sel   = 2'd2;
              pc_ld    = 1'b1;
            end
            OP_JSR: begin
              // R7 takes the already-incremented PC on the same edge PC jumps
              rf_w_wr       = 1'b1;
              rf_w_data_sel = 2'd3;
              pc_ld         = 1'b1;
              if (ir[11]) begin
                pc_sel = 2'd1;
              end else begin
                pc_sel   = 2'd2;
                rf_r1_rd = 1'b1;
              end
            end
            OP_LD, OP_LDR: begin
              mem_rd         = 1'b1;
              mem_r_addr_sel = (opcode == OP_LD) ? 2'd1 : 2'd3;
              rf_r1_rd       = (opcode == OP_LDR);
              rf_w_data_sel  = 2'd2;
              rf_w_wr        = 1'b1;
              rf_w_addr_sel  = 1'b1;
              nzp_ld         = 1'b1;
            end
            OP_LEA: begin
              rf_w_data_sel = 2'd1;
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              nzp_ld        = 1'b1;
            end
            OP_ST, OP_STR: begin
              mem_wr         = 1'b1;
              mem_w_addr_sel = (opcode == OP_ST) ? 2'd0 : 2'd2;
              rf_r1_rd       = (opcode == OP_STR);
              rf_r0_rd       = 1'b1;
            end
            OP_LDI, OP_STI: begin
              mem_rd         = 1'b1;
              mem_r_addr_sel = 2'd1;
              temp_ld        = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          if (opcode == OP_LDI) begin
            mem_rd         = 1'b1;
            mem_r_addr_sel = 2'd2;
            rf_w_data_sel  = 2'd2;
            rf_w_wr        = 1'b1;
            rf_w_addr_sel  = 1'b1;
            nzp_ld         = 1'b1;
          end else if (opcode == OP_STI) begin
            mem_wr         = 1'b1;
            mem_w_addr_sel = 2'd1;
            rf_r0_rd       = 1'b1;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control: every cycle compares the full output vector
// against a hand-built expectation.
module tb_punc_control;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       ir_clr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_r_addr_sel;
    logic [1:0] mem_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       rf_w_wr;
    logic       rf_r0_addr_sel;
    logic       rf_r0_rd;
    logic       rf_r1_rd;
    logic       temp_ld;
    logic       nzp_ld;
    logic       nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_first_val_sel;
    logic       halted;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        nzp_true;
  outs_t       got;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  punc_control dut (
    .clk               (clk),
    .rst               (rst),
    .ir                (ir),
    .nzp_true          (nzp_true),
    .pc_ld             (got.pc_ld),
    .pc_clr            (got.pc_clr),
    .pc_inc            (got.pc_inc),
    .pc_sel            (got.pc_sel),
    .ir_ld             (got.ir_ld),
    .ir_clr            (got.ir_clr),
    .mem_rd            (got.mem_rd),
    .mem_wr            (got.mem_wr),
    .mem_r_addr_sel    (got.mem_r_addr_sel),
    .mem_w_addr_sel    (got.mem_w_addr_sel),
    .rf_w_data_sel     (got.rf_w_data_sel),
    .rf_w_addr_sel     (got.rf_w_addr_sel),
    .rf_w_wr           (got.rf_w_wr),
    .rf_r0_addr_sel    (got.rf_r0_addr_sel),
    .rf_r0_rd          (got.rf_r0_rd),
    .rf_r1_rd          (got.rf_r1_rd),
    .temp_ld           (got.temp_ld),
    .nzp_ld            (got.nzp_ld),
    .nzp_clr           (got.nzp_clr),
    .alu_sel           (got.alu_sel),
    .alu_first_val_sel (got.alu_first_val_sel),
    .halted            (got.halted)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input outs_t exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic outs_t reset_e();
    outs_t e = '0;
    e.pc_clr = 1'b1; e.ir_clr = 1'b1; e.nzp_clr = 1'b1;
    return e;
  endfunction

  function automatic outs_t fetch_e();
    outs_t e = '0;
    e.mem_rd = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
    return e;
  endfunction

  // Starts in FETCH: checks FETCH and DECODE, leaves the FSM in EXEC
  task automatic fetch_decode(input string tag, input logic [15:0] instr);
    ir = instr;
    check({tag, "_fetch"}, fetch_e());
    tick;
    check({tag, "_decode"}, '0);
    tick;
  endtask

  task automatic one_exec(input string tag, input logic [15:0] instr, input outs_t e);
    fetch_decode(tag, instr);
    check({tag, "_exec"}, e);
    tick;
  endtask

  outs_t e;

  initial begin
    rst = 1'b1;
    ir = 16'h1265;
    nzp_true = 1'b0;
    tick;
    check("reset", reset_e());
    rst = 1'b0;
    #1;

    // ADD R1,R1,#5
    e = '0; e.rf_r1_rd = 1; e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1;
    e.alu_sel = 2'd1; e.alu_first_val_sel = 1;
    one_exec("add_imm", 16'h1265, e);

    // AND R1,R1,R2 (register form)
    e = '0; e.rf_r1_rd = 1; e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1;
    e.alu_sel = 2'd2; e.rf_r0_addr_sel = 1; e.rf_r0_rd = 1;
    one_exec("and_reg", 16'h5242, e);

    e = '0; e.rf_r1_rd = 1; e.alu_sel = 2'd3; e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1;
    one_exec("not", 16'h927F, e);

    nzp_true = 1'b1;
    e = '0; e.pc_ld = 1;
    one_exec("brz_taken", 16'h0403, e);
    nzp_true = 1'b0;
    one_exec("brz_not_taken", 16'h0403, '0);

    e = '0; e.rf_r1_rd = 1; e.pc_sel = 2'd2; e.pc_ld = 1;
    one_exec("jmp", 16'hC1C0, e);

    e = '0; e.rf_w_wr = 1; e.rf_w_data_sel = 2'd3; e.pc_sel = 2'd1; e.pc_ld = 1;
    one_exec("jsr", 16'h4FFE, e);
    e = '0; e.rf_w_wr = 1; e.rf_w_data_sel = 2'd3; e.pc_sel = 2'd2; e.pc_ld = 1; e.rf_r1_rd = 1;
    one_exec("jsrr", 16'h40C0, e);

    e = '0; e.mem_rd = 1; e.mem_r_addr_sel = 2'd1; e.rf_w_data_sel = 2'd2; e.rf_w_wr = 1;
    e.rf_w_addr_sel = 1; e.nzp_ld = 1;
    one_exec("ld", 16'h2401, e);
    e.mem_r_addr_sel = 2'd3; e.rf_r1_rd = 1;
    one_exec("ldr", 16'h6442, e);

    e = '0; e.rf_w_data_sel = 2'd1; e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1;
    one_exec("lea", 16'hE401, e);

    e = '0; e.mem_wr = 1; e.rf_r0_rd = 1;
    one_exec("st", 16'h3401, e);
    e.mem_w_addr_sel = 2'd2; e.rf_r1_rd = 1;
    one_exec("str", 16'h7442, e);

    one_exec("rti_nop", 16'h8000, '0);

    // LDI R2,#1: four cycles
    fetch_decode("ldi", 16'hA401);
    e = '0; e.mem_rd = 1; e.mem_r_addr_sel = 2'd1; e.temp_ld = 1;
    check("ldi_exec", e);
    tick;
    e = '0; e.mem_rd = 1; e.mem_r_addr_sel = 2'd2; e.rf_w_data_sel = 2'd2; e.rf_w_wr = 1;
    e.rf_w_addr_sel = 1; e.nzp_ld = 1;
    check("ldi_exec2", e);
    tick;

    fetch_decode("sti", 16'hB401);
    e = '0; e.mem_rd = 1; e.mem_r_addr_sel = 2'd1; e.temp_ld = 1;
    check("sti_exec", e);
    tick;
    e = '0; e.mem_wr = 1; e.mem_w_addr_sel = 2'd1; e.rf_r0_rd = 1;
    check("sti_exec2", e);
    tick;

    // Reset landing on STI's second execute cycle suppresses the write
    fetch_decode("sti_rst", 16'hB401);
    tick;
    rst = 1'b1;
    #1;
    check("sti_exec2_rst", reset_e());
    tick;
    rst = 1'b0;
    #1;
    check("after_rst_fetch", fetch_e());

    fetch_decode("halt", 16'hF025);
    e = '0; e.halted = 1;
    for (int i = 0; i < 22; i++) begin
      if (i == 10) ir = 16'h1265;
      #1;
      check("halt_hold", e);
      tick;
    end
    rst = 1'b1;
    #1;
    check("halt_rst", reset_e());
    tick;
    rst = 1'b0;
    #1;
    check("halt_rst_fetch", fetch_e());
    tick;
    check("halt_rst_decode", '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
